// File: rtl/chan_word_assembler_if.sv
// Conversion-word bus into the channel word assembler.
// The source drives frame_start/in_valid/in_data; the block returns in_ready.
interface chan_word_assembler_if #(
  parameter int WORD_W = 10
);
  logic              frame_start;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;

  modport master (
    output frame_start,
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  frame_start,
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/chan_word_assembler.sv
// Assembles 40 conversion words into eight double-buffered channel words.
// Optional idle timeout in COLLECT: define CHAN_ASM_TIMEOUT_EN.
module chan_word_assembler #(
  parameter int WORD_W       = 10,
  parameter int WORDS_PER_CH = 5,
  parameter int NUM_CH       = 8,
  parameter int TIMEOUT_CYC  = 1023,
  parameter int CH_W         = WORD_W * WORDS_PER_CH
) (
  input  logic                   iclk,
  input  logic                   rst,
  chan_word_assembler_if.slave   bus,
  input  logic                   hold,
  output logic [CH_W-1:0]        ch0,
  output logic [CH_W-1:0]        ch1,
  output logic [CH_W-1:0]        ch2,
  output logic [CH_W-1:0]        ch3,
  output logic [CH_W-1:0]        ch4,
  output logic [CH_W-1:0]        ch5,
  output logic [CH_W-1:0]        ch6,
  output logic [CH_W-1:0]        ch7,
  output logic                   frame_done,
  output logic [7:0]             frame_count,
  output logic                   abort_err,
  output logic                   overrun_err,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WAIT_SWAP
  } state_t;

  typedef logic [NUM_CH-1:0][CH_W-1:0] buf_t;

  state_t     state_q, state_d;
  buf_t       work_q, work_d;
  buf_t       ch_q, ch_d;
  logic [2:0] word_idx_q, word_idx_d;
  logic [2:0] ch_idx_q, ch_idx_d;
  logic       in_ready_q, in_ready_d;
  logic       done_q, done_d;
  logic [7:0] cnt_q, cnt_d;
  logic       abort_q, abort_d;
  logic       ovr_q, ovr_d;
`ifdef CHAN_ASM_TIMEOUT_EN
  logic [10:0] idle_q, idle_d;
  logic        tmo_q, tmo_d;
`endif

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    ch_d       = ch_q;
    word_idx_d = word_idx_q;
    ch_idx_d   = ch_idx_q;
    in_ready_d = in_ready_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    abort_d    = abort_q;
    ovr_d      = ovr_q;
`ifdef CHAN_ASM_TIMEOUT_EN
    idle_d     = '0;
    tmo_d      = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b0;
        if (bus.frame_start) begin
          state_d    = COLLECT;
          work_d     = '0;
          word_idx_d = '0;
          ch_idx_d   = '0;
          in_ready_d = 1'b1;
        end
      end
      COLLECT: begin
`ifdef CHAN_ASM_TIMEOUT_EN
        idle_d = idle_q + 11'd1;
`endif
        if (bus.frame_start) begin
          abort_d    = 1'b1;
          work_d     = '0;
          word_idx_d = '0;
          ch_idx_d   = '0;
`ifdef CHAN_ASM_TIMEOUT_EN
          idle_d     = '0;
`endif
        end else if (bus.in_valid && in_ready_q) begin
          work_d[ch_idx_q][word_idx_q*WORD_W +: WORD_W] = bus.in_data;
`ifdef CHAN_ASM_TIMEOUT_EN
          idle_d = '0;
`endif
          if (word_idx_q == 3'(WORDS_PER_CH - 1)) begin
            word_idx_d = '0;
            if (ch_idx_q == 3'(NUM_CH - 1)) begin
              ch_idx_d   = '0;
              in_ready_d = 1'b0;
              state_d    = WAIT_SWAP;
            end else begin
              ch_idx_d = ch_idx_q + 3'd1;
            end
          end else begin
            word_idx_d = word_idx_q + 3'd1;
          end
        end
`ifdef CHAN_ASM_TIMEOUT_EN
        if (state_d == COLLECT && idle_d == 11'(TIMEOUT_CYC)) begin
          tmo_d      = 1'b1;
          state_d    = IDLE;
          in_ready_d = 1'b0;
          work_d     = '0;
          idle_d     = '0;
        end
`endif
      end
      WAIT_SWAP: begin
        in_ready_d = 1'b0;
        if (bus.frame_start) ovr_d = 1'b1;
        if (!hold) begin
          ch_d    = work_q;
          cnt_d   = cnt_q + 8'd1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      work_q     <= '0;
      ch_q       <= '0;
      word_idx_q <= '0;
      ch_idx_q   <= '0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef CHAN_ASM_TIMEOUT_EN
      idle_q     <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      ch_q       <= ch_d;
      word_idx_q <= word_idx_d;
      ch_idx_q   <= ch_idx_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      ovr_q      <= ovr_d;
`ifdef CHAN_ASM_TIMEOUT_EN
      idle_q     <= idle_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign bus.in_ready = in_ready_q;
  assign ch0          = ch_q[0];
  assign ch1          = ch_q[1];
  assign ch2          = ch_q[2];
  assign ch3          = ch_q[3];
  assign ch4          = ch_q[4];
  assign ch5          = ch_q[5];
  assign ch6          = ch_q[6];
  assign ch7          = ch_q[7];
  assign frame_done   = done_q;
  assign frame_count  = cnt_q;
  assign abort_err    = abort_q;
  assign overrun_err  = ovr_q;
`ifdef CHAN_ASM_TIMEOUT_EN
  assign timeout_err  = tmo_q;
`else
  // Limit still referenced so both builds share one parameter list.
  assign timeout_err  = 1'b0 & (TIMEOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_chan_word_assembler.sv
// Scoreboard bench for chan_word_assembler.
// Expected frames are queued on the last word and popped on frame_done.
module tb_chan_word_assembler;

  typedef logic [7:0][49:0] frame_t;

  logic        iclk = 1'b0;
  logic        rst  = 1'b1;
  logic        hold = 1'b0;
  logic [49:0] ch0, ch1, ch2, ch3, ch4, ch5, ch6, ch7;
  logic [49:0] chv [8];
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        abort_err, overrun_err, timeout_err;

  chan_word_assembler_if bus ();

  chan_word_assembler dut (
    .iclk        (iclk),
    .rst         (rst),
    .bus         (bus),
    .hold        (hold),
    .ch0         (ch0),
    .ch1         (ch1),
    .ch2         (ch2),
    .ch3         (ch3),
    .ch4         (ch4),
    .ch5         (ch5),
    .ch6         (ch6),
    .ch7         (ch7),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .abort_err   (abort_err),
    .overrun_err (overrun_err),
    .timeout_err (timeout_err)
  );

  assign chv[0] = ch0;
  assign chv[1] = ch1;
  assign chv[2] = ch2;
  assign chv[3] = ch3;
  assign chv[4] = ch4;
  assign chv[5] = ch5;
  assign chv[6] = ch6;
  assign chv[7] = ch7;

  always #5 iclk = ~iclk;

  int     n_chk  = 0;
  int     n_fail = 0;
  frame_t sb[$];
  frame_t last_f = '0;
  logic [7:0] cnt_m = '0;
  logic   prev_done = 1'b0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge iclk) begin
    if (!rst) begin
      if (frame_done && prev_done)
        chk("done_pulse", 1, 0);
      if (frame_done && !prev_done) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          frame_t f;
          f = sb.pop_front();
          for (int c = 0; c < 8; c++)
            chk($sformatf("ch%0d", c), 64'(chv[c]), 64'(f[c]));
          cnt_m = cnt_m + 8'd1;
          chk("frame_count", 64'(frame_count), 64'(cnt_m));
          last_f = f;
        end
      end
      prev_done = frame_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  function automatic logic [9:0] wgen(input int mode, input int c,
                                      input int w);
    case (mode)
      0:       return 10'(c * 5 + w);
      1:       return 10'h3FF;
      2:       return 10'h155;
      default: return 10'($urandom);
    endcase
  endfunction

  task automatic pulse_start(input logic v, input logic [9:0] d);
    @(negedge iclk);
    bus.frame_start = 1'b1;
    bus.in_valid    = v;
    bus.in_data     = d;
    @(posedge iclk);
    #1;
    bus.frame_start = 1'b0;
    bus.in_valid    = 1'b0;
  endtask

  task automatic send_word(input logic [9:0] d, input bit bub);
    bit done = 0;
    int t = 0;
    while (!done) begin
      @(negedge iclk);
      bus.in_valid = bub ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = bub ? 10'($urandom) : d;
      if (bus.in_valid) bus.in_data = d;
      done = bus.in_valid && bus.in_ready;
      t++;
      if (!done && t > 100) begin
        chk("send_timeout", 0, 1);
        done = 1;
      end
      @(posedge iclk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input int mode, input bit bub,
                            input bit hold_last);
    frame_t f;
    for (int c = 0; c < 8; c++)
      for (int w = 0; w < 5; w++)
        f[c][w*10 +: 10] = wgen(mode, c, w);
    pulse_start(1'b0, 10'h0);
    for (int i = 0; i < 40; i++) begin
      if (hold_last && i == 39) hold = 1'b1;
      send_word(f[i/5][(i%5)*10 +: 10], bub);
    end
    sb.push_back(f);
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge iclk);
      t++;
    end
    if (sb.size() != 0) chk("done_timeout", 1, 0);
    @(negedge iclk);
  endtask

  initial begin
    frame_t f1;
    int bad;
    bus.frame_start = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    #12;
    for (int c = 0; c < 8; c++)
      chk($sformatf("rst_ch%0d", c), 64'(chv[c]), 0);
    chk("rst_ready", 64'(bus.in_ready), 0);
    chk("rst_done", 64'(frame_done), 0);
    chk("rst_count", 64'(frame_count), 0);
    chk("rst_flags", 64'({abort_err, overrun_err, timeout_err}), 0);
    @(negedge iclk);
    rst = 1'b0;

    pulse_start(1'b1, 10'h2A5);
    for (int i = 0; i < 40; i++)
      send_word(10'(i), 1'b0);
    for (int c = 0; c < 8; c++)
      for (int w = 0; w < 5; w++)
        f1[c][w*10 +: 10] = 10'(c * 5 + w);
    sb.push_back(f1);
    wait_done();
    chk("f1_ch0", 64'(ch0), 64'({10'd4, 10'd3, 10'd2, 10'd1, 10'd0}));
    chk("f1_ch7w4", 64'(ch7[49:40]), 64'd39);
    chk("f1_count", 64'(frame_count), 1);
    chk("f1_flags", 64'({abort_err, overrun_err, timeout_err}), 0);

    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge iclk);
      bus.in_valid = 1'b1;
      bus.in_data  = 10'h1C3;
      if (bus.in_ready) bad++;
    end
    bus.in_valid = 1'b0;
    chk("idle_ready", 64'(bad), 0);

    send_frame(1, 1'b1, 1'b0);
    wait_done();
    chk("ones_ch3", 64'(ch3), 64'h3FFFFFFFFFFFF);

    send_frame(3, 1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge iclk);
      if (i == 0) chk("wait_ready", 64'(bus.in_ready), 0);
      bus.frame_start = (i == 50);
      if (frame_done || ch0 !== last_f[0] || ch7 !== last_f[7]) bad++;
    end
    bus.frame_start = 1'b0;
    chk("hold_stable", 64'(bad), 0);
    chk("overrun", 64'(overrun_err), 1);
    hold = 1'b0;
    @(negedge iclk);
    chk("swap_next", 64'(frame_done), 1);
    wait_done();

    pulse_start(1'b0, 10'h0);
    for (int i = 0; i < 17; i++)
      send_word(10'h0AA, 1'b0);
    pulse_start(1'b1, 10'h3C3);
    chk("abort", 64'(abort_err), 1);
    for (int i = 0; i < 40; i++)
      send_word(10'h155, 1'b0);
    f1 = '0;
    for (int c = 0; c < 8; c++) f1[c] = 50'h1555555555555;
    sb.push_back(f1);
    wait_done();
    chk("abort_count", 64'(frame_count), 4);
    chk("abort_ch5", 64'(ch5), 64'h1555555555555);

    for (int k = 0; k < 252; k++) begin
      send_frame(k % 4, (k % 16) == 0, 1'b0);
      wait_done();
    end
    chk("wrap", 64'(frame_count), 0);

    pulse_start(1'b0, 10'h0);
    for (int i = 0; i < 10; i++)
      send_word(10'h2F0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    bad = 0;
    for (int c = 0; c < 8; c++)
      if (chv[c] !== '0) bad++;
    chk("arst_ch", 64'(bad), 0);
    chk("arst_misc", 64'({bus.in_ready, frame_done, frame_count,
                          abort_err, overrun_err, timeout_err}), 0);
    sb.delete();
    cnt_m  = '0;
    last_f = '0;
    @(negedge iclk);
    rst = 1'b0;
    @(negedge iclk);
    chk("arst_idle", 64'(bus.in_ready), 0);

    pulse_start(1'b0, 10'h0);
    for (int i = 0; i < 3; i++)
      send_word(10'h111, 1'b0);
    repeat (1030) @(negedge iclk);
`ifdef CHAN_ASM_TIMEOUT_EN
    chk("tmo_flag", 64'(timeout_err), 1);
    chk("tmo_idle", 64'(bus.in_ready), 0);
`else
    chk("tmo_flag", 64'(timeout_err), 0);
    chk("tmo_collect", 64'(bus.in_ready), 1);
`endif
    chk("tmo_ch0", 64'(ch0), 0);
    chk("tmo_count", 64'(frame_count), 0);
    chk("tmo_nodone", 64'(frame_done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
